// File: rtl/alu_rmw_sequencer.sv
// Read-modify-write sequencer for the 6502 ALU: READ operand, DUMMY write of the
// unmodified value while the ALU computes, WRITE the result and commit N/Z/C flags.
module alu_rmw_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  start,
  input  logic [3:0]            ctrl_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [7:0]            flag_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic [7:0]            alu_a,
  output logic [3:0]            alu_ctrl,
  output logic [7:0]            alu_flag_in,
  input  logic [7:0]            alu_out,
  input  logic [7:0]            alu_flag_out,
  output logic [7:0]            flag_out,
  output logic                  flag_we,
  output logic [1:0]            fsm_state
);

  localparam logic [3:0] C_ALU_CTRL_ADC = 4'h0;
  localparam logic [3:0] C_ALU_CTRL_SBC = 4'h1;
  localparam logic [3:0] C_ALU_CTRL_AND = 4'h2;
  localparam logic [3:0] C_ALU_CTRL_ORA = 4'h3;
  localparam logic [3:0] C_ALU_CTRL_EOR = 4'h4;
  localparam logic [3:0] C_ALU_CTRL_ASL = 4'h5;
  localparam logic [3:0] C_ALU_CTRL_LSR = 4'h6;
  localparam logic [3:0] C_ALU_CTRL_ROL = 4'h7;
  localparam logic [3:0] C_ALU_CTRL_ROR = 4'h8;
  localparam logic [3:0] C_ALU_CTRL_INC = 4'h9;
  localparam logic [3:0] C_ALU_CTRL_DEC = 4'ha;
  localparam logic [3:0] C_ALU_CTRL_BIT = 4'hb;
  localparam logic [3:0] C_ALU_CTRL_CMP = 4'hc;
  localparam logic [3:0] C_ALU_CTRL_THA = 4'hd;
  localparam logic [3:0] C_ALU_CTRL_THB = 4'he;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DUMMY = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [3:0]            op_r;
  logic [7:0]            flag_r;
  logic [7:0]            opnd_r;
  logic [7:0]            res_r;
  logic [7:0]            rflag_r;
  logic                  err_r;
  logic                  accept;
  logic                  reject;
  logic                  legal;

  assign legal = (ctrl_in == C_ALU_CTRL_ASL) || (ctrl_in == C_ALU_CTRL_LSR) ||
                 (ctrl_in == C_ALU_CTRL_ROL) || (ctrl_in == C_ALU_CTRL_ROR) ||
                 (ctrl_in == C_ALU_CTRL_INC) || (ctrl_in == C_ALU_CTRL_DEC);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      S_IDLE, S_WRITE: begin
        state_n = S_IDLE;
        if (start && legal) begin
          accept  = 1'b1;
          state_n = S_READ;
        end else if (start) begin
          reject  = 1'b1;
        end
      end
      S_READ:  state_n = S_DUMMY;
      S_DUMMY: state_n = S_WRITE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_WRITE);
    flag_we     = (state == S_WRITE);
    mem_we      = (state == S_DUMMY) || (state == S_WRITE);
    mem_addr    = addr_r;
    mem_wdata   = res_r;
    alu_a       = 8'h00;
    alu_ctrl    = C_ALU_CTRL_THA;
    alu_flag_in = flag_r;
    if (state == S_DUMMY) begin
      mem_wdata = opnd_r;
      alu_a     = opnd_r;
      alu_ctrl  = op_r;
    end
  end

  assign err       = err_r;
  assign flag_out  = rflag_r;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= S_IDLE;
      addr_r  <= '0;
      op_r    <= 4'h0;
      flag_r  <= 8'h00;
      opnd_r  <= 8'h00;
      res_r   <= 8'h00;
      rflag_r <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      state <= state_n;
      err_r <= reject;
      if (accept) begin
        addr_r <= addr_in;
        op_r   <= ctrl_in;
        // A chained op must see the carry produced by the op finishing this cycle.
        flag_r <= (state == S_WRITE) ? rflag_r : flag_in;
      end
      if (state == S_READ) opnd_r <= mem_rdata;
      if (state == S_DUMMY) begin
        res_r   <= alu_out;
        rflag_r <= alu_flag_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Bench for alu_rmw_sequencer: memory and ALU stand-ins, a reference model that predicts
// each bus transaction, and a monitor that scores DUT writes and ERR pulses against it.
module tb_alu_rmw_sequencer;

  localparam logic [3:0] ASL = 4'h5, LSR = 4'h6, ROL = 4'h7, ROR = 4'h8;
  localparam logic [3:0] INC = 4'h9, DEC = 4'ha, ADC = 4'h0, THA = 4'hd;
  localparam logic [1:0] K_RMW = 2'd1, K_ERR = 2'd2;
  localparam int W = 42;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  old;
    logic [7:0]  res;
    logic [7:0]  flags;
  } item_t;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl_in = 4'h0;
  logic [15:0] addr_in = 16'h0;
  logic [7:0]  flag_in = 8'h0;
  logic        busy, done, err, mem_we, flag_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata, mem_wdata, alu_a, alu_flag_in, alu_out, alu_flag_out, flag_out;
  logic [3:0]  alu_ctrl;
  logic [1:0]  fsm_state;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0;
  logic [7:0]  poke_data = 8'h0;

  logic [W-1:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          in_write = 1'b0;
  logic [7:0]  last_flags = 8'h0;
  logic [15:0] pool [0:7];

  alu_rmw_sequencer #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .res_n(res_n), .start(start), .ctrl_in(ctrl_in), .addr_in(addr_in),
    .flag_in(flag_in), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we), .alu_a(alu_a),
    .alu_ctrl(alu_ctrl), .alu_flag_in(alu_flag_in), .alu_out(alu_out),
    .alu_flag_out(alu_flag_out), .flag_out(flag_out), .flag_we(flag_we),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // 6502 shift/rotate/inc/dec semantics on P = {N,V,_,B,D,I,Z,C}; other codes pass A through.
  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a,
                                         input logic [7:0] p);
    logic [7:0] r;
    logic [7:0] q;
    logic       cy;
    r  = a;
    cy = p[0];
    case (c)
      ASL: begin r = a << 1;              cy = a[7]; end
      LSR: begin r = a >> 1;              cy = a[0]; end
      ROL: begin r = {a[6:0], p[0]};      cy = a[7]; end
      ROR: begin r = {p[0], a[7:1]};      cy = a[0]; end
      INC: r = a + 8'd1;
      DEC: r = a - 8'd1;
      default: return {a, p};
    endcase
    q    = p;
    q[7] = r[7];
    q[1] = (r == 8'h00);
    q[0] = cy;
    return {r, q};
  endfunction

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h5a;
  endfunction

  assign {alu_out, alu_flag_out} = alu_fn(alu_ctrl, alu_a, alu_flag_in);
  assign mem_rdata = mem[mem_addr];

  // ---------------- memory model ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    item_t it;
    if (res_n) begin
      if (flag_we || done) check("flag_we_pulse", 32'(flag_we), 32'(done));
      if (err) begin
        if (exp_q.size() == 0) fail_now("unexpected_err");
        else begin
          it = item_t'(exp_q.pop_front());
          check("err_kind", 32'(it.kind), 32'(K_ERR));
          check("err_busy", 32'(busy), 32'd0);
        end
      end
      if (mem_we && !done) begin
        if (exp_q.size() == 0) fail_now("unexpected_dummy_write");
        else begin
          it = item_t'(exp_q[0]);
          check("dummy_kind", 32'(it.kind), 32'(K_RMW));
          check("dummy_addr", 32'(mem_addr), 32'(it.addr));
          check("dummy_data", 32'(mem_wdata), 32'(it.old));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          it = item_t'(exp_q.pop_front());
          check("wr_kind", 32'(it.kind), 32'(K_RMW));
          check("wr_we", 32'(mem_we), 32'd1);
          check("wr_addr", 32'(mem_addr), 32'(it.addr));
          check("wr_data", 32'(mem_wdata), 32'(it.res));
          check("wr_flags", 32'(flag_out), 32'(it.flags));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    start     = 1'b0;
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    poke_en  = 1'b0;
    in_write = 1'b0;
  endtask

  // Drive one START; the model predicts what the DUT must do with it.
  task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [7:0] f,
                       output bit legal);
    item_t it;
    logic [7:0] p;
    start   = 1'b1;
    ctrl_in = c;
    addr_in = a;
    flag_in = f;
    legal   = (c >= ASL) && (c <= DEC);
    it      = '0;
    if (legal) begin
      p        = in_write ? last_flags : f;
      it.kind  = K_RMW;
      it.addr  = a;
      it.old   = ref_mem[a];
      {it.res, it.flags} = alu_fn(c, ref_mem[a], p);
      ref_mem[a] = it.res;
      last_flags = it.flags;
    end else begin
      it.kind = K_ERR;
    end
    exp_q.push_back(W'(it));
  endtask

  task automatic noise(input bit en);
    start   = en ? 1'($urandom_range(0, 1)) : 1'b0;
    ctrl_in = 4'($urandom);
    addr_in = 16'($urandom);
    flag_in = 8'($urandom);
  endtask

  // Leaves the bench just after the edge into WRITE (legal) or the ERR cycle (illegal).
  task automatic advance(input bit legal, input bit noisy);
    @(posedge clk); #1;
    if (legal) begin
      check("busy_read", 32'(busy), 32'd1);
      check("done_read", 32'(done), 32'd0);
      noise(noisy);
      @(posedge clk); #1;
      noise(noisy);
      @(posedge clk); #1;
      start = 1'b0;
      check("done_latency", 32'(done), 32'd1);
      in_write = 1'b1;
    end else begin
      start    = 1'b0;
      in_write = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
    in_write = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [7:0] f);
    bit legal;
    issue(c, a, f, legal);
    advance(legal, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit legal;
    logic [3:0] c;
    int v;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_flag_we", 32'(flag_we), 32'd0);
    check("rst_flag_out", 32'(flag_out), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'(THA));
    check("rst_state", 32'(fsm_state), 32'd0);
    res_n = 1'b1;
    @(posedge clk); #1;

    // ASL of 0x81 with C=0
    poke(16'h0200, 8'h81);
    run_op(ASL, 16'h0200, 8'h00);
    idle_cycle();
    check("asl_mem", 32'(mem[16'h0200]), 32'h02);
    check("asl_flags", 32'(flag_out), 32'h01);
    check("idle_flag_we", 32'(flag_we), 32'd0);

    // ROR of 0x01 with C=1
    poke(16'h0010, 8'h01);
    run_op(ROR, 16'h0010, 8'h01);
    idle_cycle();
    check("ror_mem", 32'(mem[16'h0010]), 32'h80);
    check("ror_flags", 32'(flag_out), 32'h81);

    // INC wrap to zero keeps C; DEC of zero sets N
    poke(16'h00ff, 8'hff);
    run_op(INC, 16'h00ff, 8'h01);
    idle_cycle();
    check("inc_mem", 32'(mem[16'h00ff]), 32'h00);
    check("inc_flags", 32'(flag_out), 32'h03);
    poke(16'h0040, 8'h00);
    run_op(DEC, 16'h0040, 8'h00);
    idle_cycle();
    check("dec_mem", 32'(mem[16'h0040]), 32'hff);
    check("dec_flags", 32'(flag_out), 32'h80);

    // illegal code
    run_op(ADC, 16'h1234, 8'h00);
    check("err_pulse", 32'(err), 32'd1);
    check("err_idle_busy", 32'(busy), 32'd0);
    idle_cycle();
    check("err_one_cycle", 32'(err), 32'd0);

    // back-to-back ROL chain must forward the carry
    poke(16'h0300, 8'h80);
    poke(16'h0301, 8'h00);
    run_op(ROL, 16'h0300, 8'h00);
    run_op(ROL, 16'h0301, 8'h00);
    idle_cycle();
    check("chain_mem0", 32'(mem[16'h0300]), 32'h00);
    check("chain_mem1", 32'(mem[16'h0301]), 32'h01);
    check("chain_flags", 32'(flag_out), 32'h00);

    // reset during DUMMY
    poke(16'h0400, 8'h40);
    issue(ASL, 16'h0400, 8'h00, legal);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mem_we", 32'(mem_we), 32'd1);
    res_n = 1'b0;
    #1;
    check("async_rst_mem_we", 32'(mem_we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ref_mem[16'h0400] = 8'h40;
    in_write = 1'b0;
    @(posedge clk); #1;
    res_n = 1'b1;
    check("post_rst_flags", 32'(flag_out), 32'd0);
    @(posedge clk); #1;
    run_op(ASL, 16'h0400, 8'h00);
    idle_cycle();
    check("post_rst_mem", 32'(mem[16'h0400]), 32'h80);
    check("post_rst_flags2", 32'(flag_out), 32'h80);

    // randomized traffic with back-to-back, noise and illegal codes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        v = $urandom_range(0, 9);
        c = (v < 5) ? 4'(v) : 4'(v + 6);
      end else begin
        c = 4'($urandom_range(5, 10));
      end
      issue(c, pool[$urandom_range(0, 7)], 8'($urandom), legal);
      advance(legal, 1'b1);
      if (!legal || $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
      end
    end
    idle_cycle();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
    for (int i = 0; i < 8; i++) check("final_mem", 32'(mem[pool[i]]), 32'(ref_mem[pool[i]]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
